address_unit: RTL and testbench
===============================

# address_unit

Registered, parametrised address generation unit for the 6502 core. It replaces the purely combinational address multiplexer. It selects the bus address from PC, zero page, absolute, pointer, stack and indexed sources, and adds the index register internally. A one-cycle page-cross fix-up state machine models the 6502 dummy-read/carry cycle. The block sits between the control unit/register file and the external memory address bus.

## Interface

**Parameters**
- `STACK_PAGE`, default `8'h03`: high byte of every stack address.
- `RESET_ADDR`, default `16'hFFFC`: value loaded into `address` on reset.

**Ports**
- `clk` input 1: system clock. All state updates on the rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `addr_en` input 1: load strobe. The selected address is registered on this edge.
- `address_select` input 4: addressing-mode select (see Operation).
- `force_fix` input 1: always take the fix-up cycle for indexed modes (stores, RMW).
- `index` input 8: X or Y value, chosen by the control unit.
- `pcl`, `pch` input 8 each: program counter.
- `sp` input 8: stack pointer.
- `dirl`, `dirh` input 8 each: direct operand bytes.
- `indirl`, `indirh` input 8 each: pointer / fetched-indirect bytes.
- `address` output 16: registered bus address.
- `busy` output 1: high while a fix-up cycle is pending. The control unit must stall.
- `page_cross` output 1: registered flag; the last indexed load carried out of the low byte.

## Operation

**Mode encoding.** "Load" means the value registered when `addr_en`=1 and the state is IDLE.
- 0 PC: `{pch,pcl}`
- 1 ZP: `{00,dirl}`
- 2 ABS: `{dirh,dirl}`
- 3 ZPPTR_L: `{00,indirl}`
- 4 ZPPTR_H: `{00,indirl+1}`. The low byte wraps 8'hFF→8'h00 and stays in page 0.
- 5 IND: `{indirh,indirl}`
- 6 IND1: pointer+1. The carry rule is set by Configuration.
- 7 STACK: `{STACK_PAGE,sp}`
- 8 ZP_IDX: `{00,dirl+index}`, wrapping within page 0. Never enters FIX.
- 9 ABS_IDX: base `{dirh,dirl}` plus `index`, with fix-up.
- 10 IND_IDX: base `{indirh,indirl}` plus `index`, with fix-up. This is the (zp),Y effective address.
- 11–15: reserved. `address` holds its value and the flags are unchanged.

**Fix-up state machine.** Two states, IDLE and FIX.
- IDLE, load of mode 9 or 10:
  - `{c,lo}` = base_low + `index` (9-bit sum).
  - `address` ← `{base_high, lo}`. This is the uncorrected dummy address.
  - `page_cross` ← c.
  - An internal high-byte register ← base_high + c, modulo 256.
  - If c=1 or `force_fix`=1: state → FIX. Otherwise stay in IDLE.
- FIX, next edge, unconditionally:
  - `address` ← `{fixed_high, lo}`.
  - state → IDLE.
  - `addr_en` and `address_select` are ignored during FIX.
- Any other load: `page_cross` ← 0, state stays IDLE.
- No `addr_en` in IDLE: all registers hold.
- `busy` = (state==FIX), decoded from the state register with no input path.
- Address wrap: ABS_IDX/IND_IDX at 16'hFFxx with carry wraps to 16'h00xx. The high-byte add is modulo 256.

## Timing

- Reset, asynchronous, any state:
  - `address`=`RESET_ADDR`, `busy`=0, `page_cross`=0, state=IDLE.
  - A fix-up in progress is abandoned.
- Load latency is 1 cycle. `address` is valid after the edge on which `addr_en` is sampled high.
- Indexed load with fix: edge N presents the dummy address with `busy`=1. Edge N+1 presents the corrected address with `busy`=0. Total is 2 cycles.
- Indexed load without fix: 1 cycle, `busy` stays 0.
- `addr_en` held high continuously: a new load on every IDLE edge. A load presented during FIX is lost; the control unit must re-present it after `busy` falls.
- `page_cross` holds until the next accepted load or reset.

## Configuration

- Macro `INDIRECT_PAGE_WRAP_EN`.
- **Defined:** IND1 = `{indirh, indirl+1}`. The low byte wraps and no carry reaches the high byte (NMOS JMP ($xxFF) behaviour). Example: 16'h12FF → 16'h1200.
- **Undefined:** IND1 = `{indirh,indirl}+1` with a full 16-bit carry. Example: 16'h12FF → 16'h1300; 16'hFFFF → 16'h0000.
- No other behaviour changes.

## Test plan

- **Reset:** assert `reset` mid-FIX (ABS_IDX, dirh=12, dirl=F0, index=20). Required: `address`=FFFC, `busy`=0 immediately, with no clock needed.
- **ABS_IDX, no carry:** dirh=12, dirl=10, index=05, force_fix=0. Required: one edge gives `address`=1215, `busy`=0, `page_cross`=0.
- **ABS_IDX, carry:** dirh=12, dirl=F0, index=20. Required: edge N gives 1210 with `busy`=1 and `page_cross`=1; edge N+1 gives 1310 with `busy`=0. `addr_en` with mode PC, applied at N+1, is ignored.
- **IND_IDX, force_fix, no carry:** indirh=40, indirl=00, index=01, force_fix=1. Required: 4001 with `busy`=1, then 4001 with `busy`=0 and `page_cross`=0.
- **Wrap cases:**
  - ZP_IDX dirl=F0, index=20 gives 0010.
  - ZPPTR_H indirl=FF gives 0000.
  - ABS_IDX dirh=FF, dirl=FF, index=01 gives FF00 then 0000.
  - STACK sp=FD gives 03FD.
- **IND1, pointer 12FF:** 1200 with `INDIRECT_PAGE_WRAP_EN` defined; 1300 without it.

Source files
------------

// File: rtl/address_unit.sv
// Registered 6502 address generation unit with a one-cycle page-cross fix-up state machine.
// Optional feature macro: INDIRECT_PAGE_WRAP_EN (IND1 wraps in-page like NMOS JMP ($xxFF)).
module address_unit #(
    parameter logic [7:0]  STACK_PAGE = 8'h03,
    parameter logic [15:0] RESET_ADDR = 16'hFFFC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        addr_en,
    input  logic [3:0]  address_select,
    input  logic        force_fix,
    input  logic [7:0]  index,
    input  logic [7:0]  pcl,
    input  logic [7:0]  pch,
    input  logic [7:0]  sp,
    input  logic [7:0]  dirl,
    input  logic [7:0]  dirh,
    input  logic [7:0]  indirl,
    input  logic [7:0]  indirh,
    output logic [15:0] address,
    output logic        busy,
    output logic        page_cross
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        FIX  = 1'b1
    } state_t;

    localparam logic [3:0] SEL_PC      = 4'd0;
    localparam logic [3:0] SEL_ZP      = 4'd1;
    localparam logic [3:0] SEL_ABS     = 4'd2;
    localparam logic [3:0] SEL_ZPPTR_L = 4'd3;
    localparam logic [3:0] SEL_ZPPTR_H = 4'd4;
    localparam logic [3:0] SEL_IND     = 4'd5;
    localparam logic [3:0] SEL_IND1    = 4'd6;
    localparam logic [3:0] SEL_STACK   = 4'd7;
    localparam logic [3:0] SEL_ZP_IDX  = 4'd8;
    localparam logic [3:0] SEL_ABS_IDX = 4'd9;
    localparam logic [3:0] SEL_IND_IDX = 4'd10;

    state_t      state_q, state_d;
    logic [15:0] address_q, address_d;
    logic        page_cross_q, page_cross_d;
    logic [7:0]  fix_high_q, fix_high_d;

    logic [7:0]  base_lo_s;
    logic [7:0]  base_hi_s;
    logic [8:0]  idx_sum_s;
    logic [15:0] ind1_s;

    // Indexed base selection and the 9-bit low-byte add shared by modes 9 and 10.
    always_comb begin
        base_lo_s = dirl;
        base_hi_s = dirh;
        if (address_select == SEL_IND_IDX) begin
            base_lo_s = indirl;
            base_hi_s = indirh;
        end else begin
            base_lo_s = dirl;
            base_hi_s = dirh;
        end
        idx_sum_s = {1'b0, base_lo_s} + {1'b0, index};
    end

    // Pointer+1 for the second byte of an indirect vector.
    always_comb begin
`ifdef INDIRECT_PAGE_WRAP_EN
        ind1_s = {indirh, indirl + 8'd1};
`else
        ind1_s = {indirh, indirl} + 16'd1;
`endif
    end

    // Next-state, next-address and flag logic for the IDLE/FIX machine.
    always_comb begin
        state_d      = state_q;
        address_d    = address_q;
        page_cross_d = page_cross_q;
        fix_high_d   = fix_high_q;
        case (state_q)
            IDLE: begin
                if (addr_en) begin
                    page_cross_d = 1'b0;
                    case (address_select)
                        SEL_PC:      address_d = {pch, pcl};
                        SEL_ZP:      address_d = {8'h00, dirl};
                        SEL_ABS:     address_d = {dirh, dirl};
                        SEL_ZPPTR_L: address_d = {8'h00, indirl};
                        SEL_ZPPTR_H: address_d = {8'h00, indirl + 8'd1};
                        SEL_IND:     address_d = {indirh, indirl};
                        SEL_IND1:    address_d = ind1_s;
                        SEL_STACK:   address_d = {STACK_PAGE, sp};
                        SEL_ZP_IDX:  address_d = {8'h00, dirl + index};
                        SEL_ABS_IDX, SEL_IND_IDX: begin
                            // Present the uncorrected dummy address first; the carry lands next cycle.
                            address_d    = {base_hi_s, idx_sum_s[7:0]};
                            page_cross_d = idx_sum_s[8];
                            fix_high_d   = base_hi_s + {7'd0, idx_sum_s[8]};
                            if (idx_sum_s[8] || force_fix) begin
                                state_d = FIX;
                            end else begin
                                state_d = IDLE;
                            end
                        end
                        default: begin
                            address_d    = address_q;
                            page_cross_d = page_cross_q;
                        end
                    endcase
                end else begin
                    state_d = IDLE;
                end
            end
            FIX: begin
                address_d = {fix_high_q, address_q[7:0]};
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any pending fix-up.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            address_q    <= RESET_ADDR;
            page_cross_q <= 1'b0;
            fix_high_q   <= 8'h00;
        end else begin
            state_q      <= state_d;
            address_q    <= address_d;
            page_cross_q <= page_cross_d;
            fix_high_q   <= fix_high_d;
        end
    end

    assign address    = address_q;
    assign busy       = (state_q == FIX);
    assign page_cross = page_cross_q;

endmodule

// File: tb/tb_address_unit.sv
// Directed self-checking bench for address_unit; compares {address,busy,page_cross}.
module tb_address_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        addr_en;
    logic [3:0]  address_select;
    logic        force_fix;
    logic [7:0]  index, pcl, pch, sp, dirl, dirh, indirl, indirh;
    logic [15:0] address;
    logic        busy, page_cross;

    int pass_cnt = 0;
    int total_cnt = 0;

    address_unit dut (
        .clk(clk), .reset(reset), .addr_en(addr_en), .address_select(address_select),
        .force_fix(force_fix), .index(index), .pcl(pcl), .pch(pch), .sp(sp),
        .dirl(dirl), .dirh(dirh), .indirl(indirl), .indirh(indirh),
        .address(address), .busy(busy), .page_cross(page_cross)
    );

    always #5 clk = ~clk;

    // One load edge: present mode with addr_en high, then sample 1 time unit after the edge.
    task automatic load(input logic [3:0] mode);
        address_select = mode;
        addr_en = 1'b1;
        @(posedge clk);
        #1;
        addr_en = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; addr_en = 1'b0; address_select = 4'd0; force_fix = 1'b0;
        index = 8'h00; pcl = 8'h00; pch = 8'h00; sp = 8'h00;
        dirl = 8'h00; dirh = 8'h00; indirl = 8'h00; indirh = 8'h00;
        #2;
        total_cnt++;
        if ({address, busy, page_cross} !== {16'hFFFC, 1'b0, 1'b0})
            $display("FAIL reset_initial: got %h/%b/%b want FFFC/0/0", address, busy, page_cross);
        else pass_cnt++;
        @(negedge clk);
        reset = 1'b0;
        // Enter FIX, then reset asynchronously between clock edges.
        dirh = 8'h12; dirl = 8'hF0; index = 8'h20;
        load(4'd9);
        total_cnt++;
        if ({address, busy, page_cross} !== {16'h1210, 1'b1, 1'b1})
            $display("FAIL reset_prefix: got %h/%b/%b want 1210/1/1", address, busy, page_cross);
        else pass_cnt++;
        #2 reset = 1'b1;
        #1;
        total_cnt++;
        if ({address, busy, page_cross} !== {16'hFFFC, 1'b0, 1'b0})
            $display("FAIL reset_midfix: got %h/%b/%b want FFFC/0/0", address, busy, page_cross);
        else pass_cnt++;
        #1 reset = 1'b0;
        step();
        total_cnt++;
        if ({address, busy, page_cross} !== {16'hFFFC, 1'b0, 1'b0})
            $display("FAIL reset_abandon: got %h/%b/%b want FFFC/0/0", address, busy, page_cross);
        else pass_cnt++;
    endtask

    task automatic test_abs_idx_nocarry();
        dirh = 8'h12; dirl = 8'h10; index = 8'h05; force_fix = 1'b0;
        load(4'd9);
        total_cnt++;
        if ({address, busy, page_cross} !== {16'h1215, 1'b0, 1'b0})
            $display("FAIL abs_idx_nocarry: got %h/%b/%b want 1215/0/0", address, busy, page_cross);
        else pass_cnt++;
    endtask

    task automatic test_abs_idx_carry();
        dirh = 8'h12; dirl = 8'hF0; index = 8'h20; force_fix = 1'b0;
        load(4'd9);
        total_cnt++;
        if ({address, busy, page_cross} !== {16'h1210, 1'b1, 1'b1})
            $display("FAIL abs_idx_dummy: got %h/%b/%b want 1210/1/1", address, busy, page_cross);
        else pass_cnt++;
        pch = 8'hAB; pcl = 8'hCD;
        load(4'd0);
        total_cnt++;
        if ({address, busy, page_cross} !== {16'h1310, 1'b0, 1'b1})
            $display("FAIL abs_idx_fixed: got %h/%b/%b want 1310/0/1", address, busy, page_cross);
        else pass_cnt++;
        step();
        total_cnt++;
        if ({address, busy, page_cross} !== {16'h1310, 1'b0, 1'b1})
            $display("FAIL load_in_fix_lost: got %h/%b/%b want 1310/0/1", address, busy, page_cross);
        else pass_cnt++;
        load(4'd0);
        total_cnt++;
        if ({address, busy, page_cross} !== {16'hABCD, 1'b0, 1'b0})
            $display("FAIL pc_load: got %h/%b/%b want ABCD/0/0", address, busy, page_cross);
        else pass_cnt++;
    endtask

    task automatic test_ind_idx_force();
        indirh = 8'h40; indirl = 8'h00; index = 8'h01; force_fix = 1'b1;
        load(4'd10);
        total_cnt++;
        if ({address, busy, page_cross} !== {16'h4001, 1'b1, 1'b0})
            $display("FAIL ind_idx_force_dummy: got %h/%b/%b want 4001/1/0", address, busy, page_cross);
        else pass_cnt++;
        step();
        total_cnt++;
        if ({address, busy, page_cross} !== {16'h4001, 1'b0, 1'b0})
            $display("FAIL ind_idx_force_fixed: got %h/%b/%b want 4001/0/0", address, busy, page_cross);
        else pass_cnt++;
        force_fix = 1'b0;
    endtask

    task automatic test_wrap();
        dirl = 8'hF0; index = 8'h20;
        load(4'd8);
        total_cnt++;
        if ({address, busy, page_cross} !== {16'h0010, 1'b0, 1'b0})
            $display("FAIL zp_idx_wrap: got %h/%b/%b want 0010/0/0", address, busy, page_cross);
        else pass_cnt++;
        indirl = 8'hFF;
        load(4'd4);
        total_cnt++;
        if ({address, busy, page_cross} !== {16'h0000, 1'b0, 1'b0})
            $display("FAIL zpptr_h_wrap: got %h/%b/%b want 0000/0/0", address, busy, page_cross);
        else pass_cnt++;
        sp = 8'hFD;
        load(4'd7);
        total_cnt++;
        if ({address, busy, page_cross} !== {16'h03FD, 1'b0, 1'b0})
            $display("FAIL stack: got %h/%b/%b want 03FD/0/0", address, busy, page_cross);
        else pass_cnt++;
        dirh = 8'hFF; dirl = 8'hFF; index = 8'h01;
        load(4'd9);
        total_cnt++;
        if ({address, busy, page_cross} !== {16'hFF00, 1'b1, 1'b1})
            $display("FAIL abs_idx_top_dummy: got %h/%b/%b want FF00/1/1", address, busy, page_cross);
        else pass_cnt++;
        step();
        total_cnt++;
        if ({address, busy, page_cross} !== {16'h0000, 1'b0, 1'b1})
            $display("FAIL abs_idx_top_wrap: got %h/%b/%b want 0000/0/1", address, busy, page_cross);
        else pass_cnt++;
    endtask

    task automatic test_reserved_and_hold();
        load(4'd12);
        total_cnt++;
        if ({address, busy, page_cross} !== {16'h0000, 1'b0, 1'b1})
            $display("FAIL reserved_hold: got %h/%b/%b want 0000/0/1", address, busy, page_cross);
        else pass_cnt++;
        dirh = 8'h56; dirl = 8'h78;
        load(4'd2);
        total_cnt++;
        if ({address, busy, page_cross} !== {16'h5678, 1'b0, 1'b0})
            $display("FAIL abs: got %h/%b/%b want 5678/0/0", address, busy, page_cross);
        else pass_cnt++;
        dirl = 8'h99;
        step();
        total_cnt++;
        if ({address, busy, page_cross} !== {16'h5678, 1'b0, 1'b0})
            $display("FAIL no_en_hold: got %h/%b/%b want 5678/0/0", address, busy, page_cross);
        else pass_cnt++;
    endtask

    task automatic test_ind1();
        logic [15:0] exp_a;
        logic [15:0] exp_b;
`ifdef INDIRECT_PAGE_WRAP_EN
        exp_a = 16'h1200;
        exp_b = 16'hFF00;
`else
        exp_a = 16'h1300;
        exp_b = 16'h0000;
`endif
        indirh = 8'h12; indirl = 8'hFF;
        load(4'd6);
        total_cnt++;
        if ({address, busy, page_cross} !== {exp_a, 1'b0, 1'b0})
            $display("FAIL ind1_12ff: got %h/%b/%b want %h/0/0", address, busy, page_cross, exp_a);
        else pass_cnt++;
        indirh = 8'hFF; indirl = 8'hFF;
        load(4'd6);
        total_cnt++;
        if ({address, busy, page_cross} !== {exp_b, 1'b0, 1'b0})
            $display("FAIL ind1_ffff: got %h/%b/%b want %h/0/0", address, busy, page_cross, exp_b);
        else pass_cnt++;
        load(4'd5);
        total_cnt++;
        if ({address, busy, page_cross} !== {16'hFFFF, 1'b0, 1'b0})
            $display("FAIL ind: got %h/%b/%b want FFFF/0/0", address, busy, page_cross);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_abs_idx_nocarry();
        test_abs_idx_carry();
        test_ind_idx_force();
        test_wrap();
        test_reserved_and_hold();
        test_ind1();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
